// File: rtl/alu_req_responder.sv
// Valid/ready responder for a 4-op ALU: requests are computed on acceptance and
// queued in an in-order response FIFO. Optional macro ALU_RSP_COUNT_EN adds o_rsp_count.
module alu_req_responder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned TAG_W = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [WIDTH-1:0] i_req_a,
  input  logic [WIDTH-1:0] i_req_b,
  input  logic [1:0]       i_req_op,
  input  logic [TAG_W-1:0] i_req_tag,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_result,
  output logic             o_rsp_carry,
  output logic             o_rsp_zero,
  output logic [TAG_W-1:0] o_rsp_tag
`ifdef ALU_RSP_COUNT_EN
  ,
  output logic [15:0]      o_rsp_count
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           r_mem [DEPTH];
  entry_t           r_rsp;
  logic             r_rsp_valid;
  logic             r_req_ready;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  entry_t           w_new;
  entry_t           w_head_nxt;
  logic [WIDTH:0]   w_sum;
  logic [CNT_W-1:0] w_count_nxt;
  logic [PTR_W-1:0] w_rd_nxt;

  assign w_push = i_req_valid && r_req_ready;
  assign w_pop  = r_rsp_valid && i_rsp_ready;

  // ALU evaluated on the request inputs, written to the FIFO on acceptance
  always_comb begin
    w_new = '0;
    w_sum = {1'b0, i_req_a} + {1'b0, i_req_b};
    w_new.tag = i_req_tag;
    unique case (i_req_op)
      2'b00: begin
        w_new.result = w_sum[WIDTH-1:0];
        w_new.carry  = w_sum[WIDTH];
      end
      2'b01: begin
        w_new.result = i_req_a - i_req_b;
        w_new.carry  = (i_req_a < i_req_b);
      end
      2'b10:   w_new.result = i_req_a & i_req_b;
      default: w_new.result = i_req_a | i_req_b;
    endcase
    w_new.zero = (w_new.result == '0);
  end

  // Head register tracks the entry that will sit at the FIFO head after this edge
  always_comb begin
    w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    w_rd_nxt    = r_rd_ptr + PTR_W'(1);
    w_head_nxt  = r_rsp;
    if (w_count_nxt == '0) begin
      w_head_nxt = '0;
    end else if (!r_rsp_valid) begin
      w_head_nxt = w_new;
    end else if (w_pop) begin
      w_head_nxt = (r_count == CNT_W'(1)) ? w_new : r_mem[w_rd_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_rsp       <= '0;
      r_rsp_valid <= 1'b0;
      r_req_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      r_count     <= w_count_nxt;
      r_rsp       <= w_head_nxt;
      r_rsp_valid <= (w_count_nxt != '0);
      r_req_ready <= (w_count_nxt < CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_new;
  end

  assign o_req_ready  = r_req_ready;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_rsp.result;
  assign o_rsp_carry  = r_rsp.carry;
  assign o_rsp_zero   = r_rsp.zero;
  assign o_rsp_tag    = r_rsp.tag;

`ifdef ALU_RSP_COUNT_EN
  logic [15:0] r_rsp_count;

  // Completed response handshakes, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_count <= '0;
    end else if (w_pop && (r_rsp_count != 16'hFFFF)) begin
      r_rsp_count <= r_rsp_count + 16'd1;
    end
  end

  assign o_rsp_count = r_rsp_count;
`endif

endmodule
